// File: rtl/mem_pkg.sv
// ============================================================================
// Module      : mem_pkg
// Description : Shared types, widths and address-validity helper for the
//               data-memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} mem_state_t;

  localparam int WORD_BYTES = 4;
  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;

  // Offset is word aligned and lands inside the RAM; evaluated one bit wider
  // so that the byte limit of a full-size RAM cannot overflow.
  function automatic logic mem_addr_ok(input logic [ADDR_W-1:0] offset,
                                       input int unsigned depth);
    logic [ADDR_W:0] limit;
    limit = (ADDR_W+1)'(depth) * (ADDR_W+1)'(WORD_BYTES);
    return (offset[1:0] == 2'b00) && ({1'b0, offset} < limit);
  endfunction

endpackage

`default_nettype wire

// File: rtl/data_mem_responder_sync_ram.sv
// ============================================================================
// Module      : sync_ram
// Description : Single-port word RAM with registered read and write enable.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_ram #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        r_mem[addr] <= wdata;
      end else begin
        r_rdata <= r_mem[addr];
      end
    end
  end

  assign rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/data_mem_responder.sv
// ============================================================================
// Module      : data_mem_responder
// Description : Data-memory responder: request latch, wait-state FSM, address
//               decode and one-cycle ready/err response over a synchronous RAM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_mem_responder
  import mem_pkg::*;
#(
  parameter int              DEPTH_WORDS = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_0000,
  parameter int              WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              err
);

  localparam int         IDX_W         = $clog2(DEPTH_WORDS);
  localparam logic [3:0] c_wait_states = 4'(WAIT_STATES);

  mem_state_t        r_state;
  logic [3:0]        r_cnt;
  logic              r_we;
  logic              r_ok;
  logic [IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_wdata;

  logic [ADDR_W-1:0] w_offset;
  logic              w_ok;
  logic [IDX_W-1:0]  w_idx;
  logic              w_accept;
  logic              w_commit;
  logic              w_ram_en;
  logic [IDX_W-1:0]  w_ram_addr;
  logic [DATA_W-1:0] w_ram_rdata;

  assign w_offset = addr - BASE_ADDR;
  assign w_ok     = mem_addr_ok(w_offset, DEPTH_WORDS);
  assign w_idx    = w_offset[IDX_W+1:2];
  assign w_accept = (r_state == IDLE) && req;

  // Loads read on the acceptance edge; stores commit on the edge leaving RESP.
  // The two never coincide, so one RAM port serves both. A reset on the
  // leaving edge suppresses the commit.
  assign w_commit   = (r_state == RESP) && r_we && r_ok && rst;
  assign w_ram_en   = (w_accept && !we && w_ok && rst) || w_commit;
  assign w_ram_addr = w_commit ? r_idx : w_idx;

  sync_ram #(
    .DEPTH (DEPTH_WORDS),
    .WIDTH (DATA_W)
  ) u_ram (
    .clk   (clk),
    .en    (w_ram_en),
    .we    (w_commit),
    .addr  (w_ram_addr),
    .wdata (r_wdata),
    .rdata (w_ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_ok    <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req) begin
            r_we    <= we;
            r_ok    <= w_ok;
            r_idx   <= w_idx;
            r_wdata <= wdata;
            r_cnt   <= c_wait_states;
            r_state <= (WAIT_STATES > 0) ? WAIT : RESP;
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt <= 4'd1) begin
            r_state <= RESP;
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign ready = (r_state == RESP);
  assign err   = ready && !r_ok;
  assign rdata = (ready && r_ok && !r_we) ? w_ram_rdata : '0;

endmodule

`default_nettype wire
